// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared types and constants for the memory bus arbiter:
//   arb_state_t  - arbiter FSM state (idle / address phase / data phase)
//   arb_grant_t  - which requester owns the bus (fetch or data)
//   mem_size_t   - sram-like access size encoding
//   MEM_SIZE_*   - size constants; fetches always use MEM_SIZE_WORD
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        G_FETCH = 1'b0,
        G_DATA  = 1'b1
    } arb_grant_t;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t MEM_SIZE_BYTE = 2'd0;
    localparam mem_size_t MEM_SIZE_HALF = 2'd1;
    localparam mem_size_t MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection between the fetch and data requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   - round-robin; on contention the requester not served last wins
//   undefined - fixed priority, data over fetch (no last-served input)
// Ports:
//   i_req           in  fetch request
//   d_req           in  data request
//   i_last_served   in  requester served most recently (round-robin only)
//   o_winner        out selected requester
//   o_valid         out at least one request is present
// -----------------------------------------------------------------------------
module arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  arb_grant_t i_last_served,
`endif
    output arb_grant_t o_winner,
    output logic       o_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_valid  = i_req | d_req;
        o_winner = G_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            o_winner = (i_last_served == G_DATA) ? G_FETCH : G_DATA;
        end else if (d_req) begin
            o_winner = G_DATA;
        end
`else
        if (d_req) begin
            o_winner = G_DATA;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one sram-like memory bus between the CPU fetch path (i_*) and the
// load/store path (d_*). One transaction outstanding at a time; the grant is
// locked from arbitration until the bus returns m_data_ok.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin instead of data-first).
// Ports:
//   clk, resetn                      clock, async active-low reset
//   i_req/i_addr                     fetch request in
//   i_addr_ok/i_data_ok/i_rdata      fetch handshake/data out
//   d_req/d_wr/d_size/d_addr/
//   d_wdata/d_wstrb                  data request in
//   d_addr_ok/d_data_ok/d_rdata      data handshake/data out
//   m_req/m_wr/m_size/m_addr/
//   m_wdata/m_wstrb                  bus request out
//   m_addr_ok/m_data_ok/m_rdata      bus handshake/data in
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_req,
    input  logic [31:0]     i_addr,
    output logic            i_addr_ok,
    output logic            i_data_ok,
    output logic [31:0]     i_rdata,
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [1:0]      d_size,
    input  logic [31:0]     d_addr,
    input  logic [31:0]     d_wdata,
    input  logic [3:0]      d_wstrb,
    output logic            d_addr_ok,
    output logic            d_data_ok,
    output logic [31:0]     d_rdata,
    output logic            m_req,
    output logic            m_wr,
    output logic [1:0]      m_size,
    output logic [31:0]     m_addr,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    input  logic            m_addr_ok,
    input  logic            m_data_ok,
    input  logic [31:0]     m_rdata
);

    arb_state_t r_state;
    arb_grant_t r_grant;
    arb_grant_t w_pick_winner;
    logic       w_pick_valid;
    logic       w_gnt_req;
    logic       w_in_addr;
    logic       w_in_data;
    logic       w_gnt_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_grant_t r_last_served;
`endif

    arb_pick u_arb_pick (
        .i_req         (i_req),
        .d_req         (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .i_last_served (r_last_served),
`endif
        .o_winner      (w_pick_winner),
        .o_valid       (w_pick_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_grant       <= G_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_served <= G_FETCH;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_winner;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // An ack while the owner has dropped its request is not a handshake.
                    if (m_addr_ok && w_gnt_req) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_data_ok) begin
                        r_state <= S_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_served <= r_grant;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_gnt_data = (r_grant == G_DATA);
    assign w_gnt_req  = w_gnt_data ? d_req : i_req;
    assign w_in_addr  = (r_state == S_ADDR);
    assign w_in_data  = (r_state == S_DATA);

    // Bus side: payload is only presented during the address phase, zero otherwise.
    always_comb begin
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_size  = MEM_SIZE_BYTE;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_wstrb = 4'd0;
        if (w_in_addr) begin
            m_req = w_gnt_req;
            if (w_gnt_data) begin
                m_wr    = d_wr;
                m_size  = d_size;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
            end else begin
                m_size  = MEM_SIZE_WORD;
                m_addr  = i_addr;
            end
        end
    end

    // Requester side: handshakes are pure pass-through to the current owner.
    assign i_addr_ok = w_in_addr && w_gnt_req && m_addr_ok && !w_gnt_data;
    assign d_addr_ok = w_in_addr && w_gnt_req && m_addr_ok &&  w_gnt_data;
    assign i_data_ok = w_in_data && m_data_ok && !w_gnt_data;
    assign d_data_ok = w_in_data && m_data_ok &&  w_gnt_data;

    // Read data is gated off in idle so nothing leaks out after reset.
    assign i_rdata = (r_state != S_IDLE && !w_gnt_data) ? m_rdata : 32'd0;
    assign d_rdata = (r_state != S_IDLE &&  w_gnt_data) ? m_rdata : 32'd0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (resetn) begin
            assert (!(m_data_ok && !w_in_data))
                else $warning("mem_bus_arbiter: m_data_ok outside data phase ignored");
            assert (!(w_in_addr && !w_gnt_req))
                else $warning("mem_bus_arbiter: granted requester dropped req before addr_ok");
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge. Expected
// values are hand-computed; MEM_ARB_ROUND_ROBIN_EN selects the contention
// expectations to match the build.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_bus_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic exp_d;

        // ---------------- reset: outputs forced to zero ----------------
        resetn = 1'b0;
        i_req = 1'b1; i_addr = 32'hBFC00000;
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h80000000;
        d_wdata = 32'h11111111; d_wstrb = 4'hF;
        m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = 32'h12345678;
        tick(); tick();
        #1;
        check("rst_m_req",     m_req,     0);
        check("rst_m_addr",    m_addr,    0);
        check("rst_m_wr",      m_wr,      0);
        check("rst_m_size",    m_size,    0);
        check("rst_m_wdata",   m_wdata,   0);
        check("rst_m_wstrb",   m_wstrb,   0);
        check("rst_i_addr_ok", i_addr_ok, 0);
        check("rst_d_addr_ok", d_addr_ok, 0);
        check("rst_i_rdata",   i_rdata,   0);
        check("rst_d_rdata",   d_rdata,   0);

        tick();
        resetn = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        m_addr_ok = 1'b0; m_rdata = 32'h0;

        // ---------------- single fetch ----------------
        tick();
        i_req = 1'b1; i_addr = 32'hBFC00000;
        #1;
        check("f_idle_m_req", m_req, 0);
        tick();
        #1;
        check("f_m_req",  m_req,  1);
        check("f_m_addr", m_addr, 32'hBFC00000);
        check("f_m_size", m_size, 2);
        check("f_m_wr",   m_wr,   0);
        check("f_m_wstrb", m_wstrb, 0);
        check("f_addr_ok_early", i_addr_ok, 0);
        m_addr_ok = 1'b1;
        #1;
        check("f_i_addr_ok", i_addr_ok, 1);
        check("f_d_addr_ok", d_addr_ok, 0);
        tick();
        m_addr_ok = 1'b0; i_req = 1'b0;
        m_data_ok = 1'b1; m_rdata = 32'h24080001;
        #1;
        check("f_data_m_req", m_req,     0);
        check("f_i_data_ok",  i_data_ok, 1);
        check("f_i_rdata",    i_rdata,   32'h24080001);
        check("f_d_data_ok",  d_data_ok, 0);
        check("f_d_rdata",    d_rdata,   0);
        tick();
        m_data_ok = 1'b0;
        i_req = 1'b1; i_addr = 32'hBFC00010;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h80000020;
        d_wdata = 32'h0; d_wstrb = 4'h0;
        #1;
        check("f_done_i_data_ok", i_data_ok, 0);
        check("f_done_i_rdata",   i_rdata,   0);

        // ---------------- contention, both held high ----------------
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #1;
            check("c_arb_m_req", m_req, 0);
            tick();
            m_addr_ok = 1'b1;
            #1;
            check("c_d_addr_ok", d_addr_ok, exp_d);
            check("c_i_addr_ok", i_addr_ok, !exp_d);
            check("c_m_addr",    m_addr,    exp_d ? 32'h80000020 : 32'hBFC00010);
            tick();
            m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hA0 + k;
            #1;
            check("c_d_data_ok", d_data_ok, exp_d);
            check("c_i_data_ok", i_data_ok, !exp_d);
            check("c_rdata", exp_d ? d_rdata : i_rdata, 32'hA0 + k);
            tick();
            m_data_ok = 1'b0;
        end

        // data drops out: pending fetch is served
        d_req = 1'b0;
        #1;
        check("c_tail_m_req", m_req, 0);
        tick();
        m_addr_ok = 1'b1;
        #1;
        check("c_tail_i_addr_ok", i_addr_ok, 1);
        check("c_tail_d_addr_ok", d_addr_ok, 0);
        tick();
        m_addr_ok = 1'b0; i_req = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0BADF00D;
        #1;
        check("c_tail_i_data_ok", i_data_ok, 1);
        tick();
        m_data_ok = 1'b0;

        // ---------------- data write ----------------
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h80000010;
        d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        #1;
        check("w_idle_m_req", m_req, 0);
        tick();
        #1;
        check("w_m_req",   m_req,   1);
        check("w_m_wr",    m_wr,    1);
        check("w_m_size",  m_size,  2);
        check("w_m_addr",  m_addr,  32'h80000010);
        check("w_m_wdata", m_wdata, 32'hDEADBEEF);
        check("w_m_wstrb", m_wstrb, 4'hF);
        m_addr_ok = 1'b1;
        #1;
        check("w_d_addr_ok", d_addr_ok, 1);
        check("w_i_addr_ok", i_addr_ok, 0);
        tick();
        m_addr_ok = 1'b0; d_req = 1'b0;
        #1;
        check("w_d_addr_ok_pulse", d_addr_ok, 0);
        check("w_data_m_req",      m_req,     0);
        m_data_ok = 1'b1;
        #1;
        check("w_d_data_ok", d_data_ok, 1);
        check("w_i_data_ok", i_data_ok, 0);
        tick();
        m_data_ok = 1'b0;
        #1;
        check("w_d_data_ok_pulse", d_data_ok, 0);

        // ---------------- stall: 5 cycles addr, 3 cycles data ----------------
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd1; d_addr = 32'h80000042;
        d_wdata = 32'h0; d_wstrb = 4'h3;
        #1;
        check("s_idle_m_req", m_req, 0);
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 1) begin
                i_req = 1'b1; i_addr = 32'hBFC00020;
            end
            #1;
            check("s_addr_m_req",     m_req,     1);
            check("s_addr_m_addr",    m_addr,    32'h80000042);
            check("s_addr_m_size",    m_size,    1);
            check("s_addr_d_addr_ok", d_addr_ok, 0);
        end
        tick();
        m_addr_ok = 1'b1;
        #1;
        check("s_d_addr_ok", d_addr_ok, 1);
        check("s_i_addr_ok", i_addr_ok, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            m_addr_ok = 1'b0; d_req = 1'b0;
            #1;
            check("s_data_m_req",     m_req,     0);
            check("s_data_d_data_ok", d_data_ok, 0);
            check("s_data_i_addr_ok", i_addr_ok, 0);
        end
        tick();
        m_data_ok = 1'b1; m_rdata = 32'h5A5A1234;
        #1;
        check("s_d_data_ok", d_data_ok, 1);
        check("s_d_rdata",   d_rdata,   32'h5A5A1234);
        check("s_i_rdata",   i_rdata,   0);
        tick();
        m_data_ok = 1'b0;
        #1;
        check("s_fetch_arb_m_req", m_req, 0);

        // waiting fetch is served afterwards, then reset lands in its data phase
        tick();
        #1;
        check("r_m_req",  m_req,  1);
        check("r_m_addr", m_addr, 32'hBFC00020);
        m_addr_ok = 1'b1;
        #1;
        check("r_i_addr_ok", i_addr_ok, 1);
        tick();
        m_addr_ok = 1'b0; i_req = 1'b0; m_rdata = 32'hCAFEF00D;
        #1;
        check("r_pre_i_rdata", i_rdata, 32'hCAFEF00D);
        resetn = 1'b0; m_data_ok = 1'b1;
        #1;
        check("r_rst_m_req",     m_req,     0);
        check("r_rst_i_rdata",   i_rdata,   0);
        check("r_rst_i_data_ok", i_data_ok, 0);
        tick();
        resetn = 1'b1;
        #1;
        check("r_stale_i_data_ok", i_data_ok, 0);
        check("r_stale_d_data_ok", d_data_ok, 0);
        check("r_stale_m_req",     m_req,     0);
        tick();
        m_data_ok = 1'b0; i_req = 1'b1; i_addr = 32'hBFC00100;
        #1;
        check("r_new_idle_m_req", m_req, 0);
        tick();
        #1;
        check("r_new_m_req",  m_req,  1);
        check("r_new_m_addr", m_addr, 32'hBFC00100);
        m_addr_ok = 1'b1;
        #1;
        check("r_new_i_addr_ok", i_addr_ok, 1);
        tick();
        m_addr_ok = 1'b0; i_req = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h11112222;
        #1;
        check("r_new_i_data_ok", i_data_ok, 1);
        check("r_new_i_rdata",   i_rdata,   32'h11112222);
        tick();
        m_data_ok = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between the fetch path and the load/store path of the multi-cycle reference CPU. Both requesters and the downstream bus use the sram-like split handshake: `req` is held until `addr_ok`, then `data_ok` returns later. At most one transaction is outstanding, and the grant is locked from arbitration until its `data_ok`. Sits between the CPU core (fetch and S_ADDR_CHECK-onward memory states) and the cache/bridge.

## Interface
Parameters:
- none; address and data are 32 bits, strobe is 4 bits, size is 2 bits (fixed by the package).

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset; one clock; reset is asynchronous and active-low.
- `i_req` in 1: fetch request valid.
- `i_addr` in 32: fetch address.
- `i_addr_ok` out 1: fetch address accepted.
- `i_data_ok` out 1: fetch data valid.
- `i_rdata` out 32: fetch read data.
- `d_req` in 1: data request valid.
- `d_wr` in 1: data request is a write.
- `d_size` in 2: data access size (0=byte, 1=half, 2=word).
- `d_addr` in 32: data address.
- `d_wdata` in 32: data write data.
- `d_wstrb` in 4: data byte strobes.
- `d_addr_ok` out 1: data address accepted.
- `d_data_ok` out 1: data complete or read data valid.
- `d_rdata` out 32: data read data.
- `m_req` out 1: bus request.
- `m_wr` out 1: bus request is a write.
- `m_size` out 2: bus access size.
- `m_addr` out 32: bus address.
- `m_wdata` out 32: bus write data.
- `m_wstrb` out 4: bus byte strobes.
- `m_addr_ok` in 1: bus address accepted.
- `m_data_ok` in 1: bus data valid.
- `m_rdata` in 32: bus read data.

## Operation
- FSM states: `S_IDLE`, `S_ADDR`, `S_DATA`, plus a registered `grant` (`G_FETCH` or `G_DATA`).
- **S_IDLE**
  - If `i_req` or `d_req` is high, pick the winner, register `grant`, and go to `S_ADDR`.
  - No requests: stay in `S_IDLE`.
- **S_ADDR**
  - `m_*` outputs are muxed combinationally from the granted requester's inputs.
  - When the granted requester is fetch: `m_wr`=0, `m_size`=2, `m_wstrb`=0, `m_wdata`=0.
  - On `m_addr_ok`: pulse the granted `x_addr_ok` in the same cycle and go to `S_DATA`.
- **S_DATA**
  - `m_req`=0.
  - On `m_data_ok`: pulse the granted `x_data_ok` in the same cycle, pass `m_rdata` to the granted `x_rdata`, update the priority state, and go to `S_IDLE`.
- Ungranted `x_addr_ok` and `x_data_ok` are always 0.
- `x_rdata` equals `m_rdata` when granted, else 0.
- Boundaries:
  - Both requesters high in `S_IDLE`: the priority rule decides (see Configuration).
  - `m_data_ok` outside `S_DATA` is ignored; a simulation assertion fires.
  - `m_addr_ok` outside `S_ADDR` is ignored.
  - A requester dropping `req` during `S_ADDR` is a protocol violation: `m_req` follows it low and the FSM waits. A simulation assertion fires.
  - A new request arriving while busy waits; it is never reordered ahead of the outstanding one.
  - Reset mid-transaction: FSM returns to `S_IDLE` immediately and the in-flight transaction is dropped. The bus owner must also be reset.

## Timing
- Reset values:
  - State: `S_IDLE`, `grant`=`G_FETCH`, last-served=`G_FETCH`.
  - Outputs: all `m_*`, `x_addr_ok`, `x_data_ok` and `x_rdata` = 0.
- Arbitration latency: 1 cycle. A request seen in `S_IDLE` at cycle N drives `m_req` at N+1.
- Minimum transaction: request at N, `m_addr_ok` at N+1, `m_data_ok` at N+2. The next arbitration happens at N+3.
- `addr_ok` and `data_ok` are pure combinational pass-through, with zero added latency.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin. When both request, the requester not served last wins. The last-served register updates at `data_ok`.
  - Undefined: fixed priority, `d_req` over `i_req`. The last-served register is not implemented.

## Structure
- Shared package:
  - `arb_state_t` (`S_IDLE`/`S_ADDR`/`S_DATA`)
  - `arb_grant_t` (`G_FETCH`/`G_DATA`)
  - `mem_size_t`
  - `MEM_SIZE_WORD` constant
- One combinational sub-module `arb_pick`. Inputs: `i_req`, `d_req`, last-served. Outputs: winner, valid. It contains the macro-dependent priority logic.

## Test plan
- **Single fetch.** `i_req`=1, `i_addr`=0xBFC00000, bus acks 1 cycle later, `m_rdata`=0x24080001 → `m_req` high with `m_addr`=0xBFC00000, `m_size`=2, `m_wr`=0; then `i_addr_ok` pulses, then `i_data_ok` pulses with `i_rdata`=0x24080001; `d_*_ok` stay 0.
- **Data write.** `d_req`=1, `d_wr`=1, `d_addr`=0x80000010, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF → exact values appear on `m_*`; `d_addr_ok` then `d_data_ok` each pulse for 1 cycle.
- **Contention, fixed priority (macro off).** Both request continuously for 4 transactions → all 4 grants go to data; fetch is served only after `d_req` drops.
- **Contention, round-robin (macro on).** Both request continuously → grants alternate data, fetch, data, fetch.
- **Stall.** Bus holds `m_addr_ok` low for 5 cycles and `m_data_ok` low for 3 → `m_req` and payload stay stable; no ok pulse reaches either requester early.
- **Reset mid-operation.** Assert `resetn`=0 in `S_DATA` → all outputs 0 within the same cycle. After release, an `i_req` is granted normally and a stale `m_data_ok` is ignored.
